// File: rtl/add16se_rr_sched.sv
// -----------------------------------------------------------------------------
// add16se_rr_sched
//
// Round-robin scheduler that time-shares one external combinational 16-bit
// sign-extended adder among NREQ requesters. One operation is outstanding at
// a time: the winner's operands are registered onto the adder inputs, the
// 17-bit adder output is captured, and the result is returned together with
// the requester index on a single valid/ready response channel. The sum is
// never inspected, so exact and approximate adder variants plug in unchanged.
//
// Configuration macro: ADD16SE_SCHED_OREG_EN
//   defined   : adds a register on add_o and a CAPT state (latency 3 cycles)
//   undefined : add_o captured directly into rsp_sum (latency 2 cycles)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   req_valid  in   [NREQ]      per-requester operand valid
//   req_ready  out  [NREQ]      per-requester grant, one-hot or zero (comb)
//   req_a      in   [16*NREQ]   operand A, requester i at [16i+15:16i]
//   req_b      in   [16*NREQ]   operand B, same packing
//   add_a      out  [16]        shared adder operand A (registered)
//   add_b      out  [16]        shared adder operand B (registered)
//   add_o      in   [17]        shared adder result
//   rsp_valid  out              result valid (registered)
//   rsp_ready  in               result accepted
//   rsp_sum    out  [17]        captured adder result
//   rsp_id     out  [IDW]       requester index owning rsp_sum
//   busy       out              high whenever not IDLE
//   ops_cnt    out  [16]        completed response handshakes, wrapping
// -----------------------------------------------------------------------------
module add16se_rr_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic [15:0]          add_a,
  output logic [15:0]          add_b,
  input  logic [16:0]          add_o,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [16:0]          rsp_sum,
  output logic [IDW-1:0]       rsp_id,
  output logic                 busy,
  output logic [15:0]          ops_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
`ifdef ADD16SE_SCHED_OREG_EN
  localparam logic [1:0] S_CAPT  = 2'd2;
`endif
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);
  localparam logic [IDW:0]   NREQ_W   = (IDW + 1)'(NREQ);

  logic [1:0]     r_state;
  logic [IDW-1:0] r_ptr;
  logic [15:0]    r_add_a;
  logic [15:0]    r_add_b;
  logic           r_rsp_valid;
  logic [16:0]    r_rsp_sum;
  logic [IDW-1:0] r_rsp_id;
  logic [15:0]    r_ops_cnt;
`ifdef ADD16SE_SCHED_OREG_EN
  logic [16:0]    r_oreg;
`endif

  logic [15:0]    w_op_a [NREQ];
  logic [15:0]    w_op_b [NREQ];
  logic           w_any;
  logic [IDW-1:0] w_win;
  logic [IDW:0]   w_scan;
  logic           w_grant_en;
  logic [IDW-1:0] w_ptr_next;

  // Unpack the flat operand buses into per-requester words.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_op_a[gi] = req_a[16*gi +: 16];
      assign w_op_b[gi] = req_b[16*gi +: 16];
    end
  endgenerate

  // Round-robin pick: scan offsets from the highest down so the last match,
  // i.e. the one closest to r_ptr in the circular order, wins.
  always_comb begin
    w_any  = 1'b0;
    w_win  = '0;
    w_scan = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_scan = {1'b0, r_ptr} + (IDW + 1)'(k);
      if (w_scan >= NREQ_W) begin
        w_scan = w_scan - NREQ_W;
      end
      if (req_valid[w_scan[IDW-1:0]]) begin
        w_any = 1'b1;
        w_win = w_scan[IDW-1:0];
      end
    end
  end

  // A grant is possible when idle, or when the held result leaves this cycle.
  // Reset is folded in so req_ready reads zero while reset is asserted.
  assign w_grant_en = !rst && w_any &&
                      ((r_state == S_IDLE) || ((r_state == S_HOLD) && rsp_ready));

  assign w_ptr_next = (w_win == LAST_IDX) ? '0 : (w_win + IDW'(1));

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = w_grant_en && (w_win == IDW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_sum   <= '0;
      r_rsp_id    <= '0;
      r_ops_cnt   <= '0;
`ifdef ADD16SE_SCHED_OREG_EN
      r_oreg      <= '0;
`endif
    end else begin
      // Operands and owner index change only on a grant; they otherwise keep
      // the last operation's values.
      if (w_grant_en) begin
        r_add_a  <= w_op_a[w_win];
        r_add_b  <= w_op_b[w_win];
        r_rsp_id <= w_win;
        r_ptr    <= w_ptr_next;
      end

      case (r_state)
        S_IDLE: begin
          if (w_grant_en) begin
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
`ifdef ADD16SE_SCHED_OREG_EN
          r_oreg  <= add_o;
          r_state <= S_CAPT;
`else
          r_rsp_sum   <= add_o;
          r_rsp_valid <= 1'b1;
          r_state     <= S_HOLD;
`endif
        end
`ifdef ADD16SE_SCHED_OREG_EN
        S_CAPT: begin
          r_rsp_sum   <= r_oreg;
          r_rsp_valid <= 1'b1;
          r_state     <= S_HOLD;
        end
`endif
        S_HOLD: begin
          if (rsp_ready) begin
            r_ops_cnt   <= r_ops_cnt + 16'd1;
            r_rsp_valid <= 1'b0;
            r_state     <= w_grant_en ? S_ISSUE : S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign add_a     = r_add_a;
  assign add_b     = r_add_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_sum   = r_rsp_sum;
  assign rsp_id    = r_rsp_id;
  assign ops_cnt   = r_ops_cnt;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_add16se_rr_sched.sv
module tb_add16se_rr_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
`ifdef ADD16SE_SCHED_OREG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [16*NREQ-1:0]  req_a;
  logic [16*NREQ-1:0]  req_b;
  logic [15:0]         add_a;
  logic [15:0]         add_b;
  logic [16:0]         add_o;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [16:0]         rsp_sum;
  logic [IDW-1:0]      rsp_id;
  logic                busy;
  logic [15:0]         ops_cnt;

  logic [NREQ-1:0]     tb_valid;
  logic [15:0]         tb_a [NREQ];
  logic [15:0]         tb_b [NREQ];

  always #5 clk = ~clk;

  assign req_valid = tb_valid;
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
      assign req_a[16*gi +: 16] = tb_a[gi];
      assign req_b[16*gi +: 16] = tb_b[gi];
    end
  endgenerate

  // External exact sign-extended adder.
  assign add_o = {add_a[15], add_a} + {add_b[15], add_b};

  add16se_rr_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .add_a(add_a), .add_b(add_b), .add_o(add_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_id(rsp_id),
    .busy(busy), .ops_cnt(ops_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (p + k) % NREQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [16:0] ref_sum(input logic [15:0] a, input logic [15:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    return s[16:0];
  endfunction

  function automatic logic [15:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'hFFFF;
      3: return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  int              cyc = 0;
  int              m_ptr;
  logic [15:0]     m_cnt;
  logic [15:0]     m_add_a;
  logic [15:0]     m_add_b;
  int              q_id [$];
  logic [16:0]     q_sum [$];
  int              q_t [$];
  int              gnt_log [$];
  int              gnt_cyc [$];
  logic [NREQ-1:0] last_gnt;

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle monitor: compares DUT against the model, then advances the model.
  always @(negedge clk) begin
    int              g;
    logic [NREQ-1:0] exp_mask;
    logic            exp_v;
    logic            hs;
    if (rst) begin
      chk("rst_req_ready", 32'(req_ready), 32'(0));
      chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("rst_busy",      32'(busy),      32'(0));
      chk("rst_ops_cnt",   32'(ops_cnt),   32'(0));
      chk("rst_add_a",     32'(add_a),     32'(0));
      chk("rst_add_b",     32'(add_b),     32'(0));
      chk("rst_rsp_sum",   32'(rsp_sum),   32'(0));
      chk("rst_rsp_id",    32'(rsp_id),    32'(0));
      m_ptr = 0;
      m_cnt = '0;
      m_add_a = '0;
      m_add_b = '0;
      q_id.delete();
      q_sum.delete();
      q_t.delete();
      last_gnt = '0;
    end else begin
      exp_v = (q_id.size() > 0) && (cyc >= q_t[0] + LAT);
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
      if (exp_v) begin
        chk("rsp_sum", 32'(rsp_sum), 32'(q_sum[0]));
        chk("rsp_id",  32'(rsp_id),  32'(q_id[0]));
      end
      chk("busy",    32'(busy),    32'(q_id.size() > 0));
      chk("ops_cnt", 32'(ops_cnt), 32'(m_cnt));
      chk("add_a",   32'(add_a),   32'(m_add_a));
      chk("add_b",   32'(add_b),   32'(m_add_b));
      hs = exp_v && rsp_ready;
      g = -1;
      exp_mask = '0;
      if ((q_id.size() == 0) || hs) g = rr_pick(req_valid, m_ptr);
      if (g >= 0) exp_mask[g] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_mask));
      last_gnt = req_ready;
      if (hs) begin
        void'(q_id.pop_front());
        void'(q_sum.pop_front());
        void'(q_t.pop_front());
        m_cnt = m_cnt + 16'd1;
      end
      if (g >= 0) begin
        q_id.push_back(g);
        q_sum.push_back(ref_sum(tb_a[g], tb_b[g]));
        q_t.push_back(cyc);
        m_ptr = (g + 1) % NREQ;
        m_add_a = tb_a[g];
        m_add_b = tb_b[g];
        gnt_log.push_back(g);
        gnt_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- stimulus tasks (enter/exit just after a posedge) --------
  task automatic run_cycles(input int n, input bit renew, input bit rnd);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (last_gnt[i]) begin
          tb_a[i] = rnd_op();
          tb_b[i] = rnd_op();
          tb_valid[i] = renew ? 1'b1 : 1'($urandom_range(0, 1));
        end else if (rnd) begin
          if (!tb_valid[i]) begin
            if ($urandom_range(0, 2) == 0) begin
              tb_a[i] = rnd_op();
              tb_b[i] = rnd_op();
              tb_valid[i] = 1'b1;
            end
          end else if ($urandom_range(0, 15) == 0) begin
            tb_valid[i] = 1'b0;
          end
        end
      end
      if (rnd) rsp_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic drain();
    tb_valid = '0;
    rsp_ready = 1'b1;
    repeat (LAT + 3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tb_valid = '0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic do_single(input int idx, input logic [15:0] a, input logic [15:0] b,
                           input logic [16:0] exp_sum, input logic [15:0] exp_cnt);
    logic [NREQ-1:0] m;
    m = '0;
    m[idx] = 1'b1;
    tb_valid = m;
    tb_a[idx] = a;
    tb_b[idx] = b;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("single_ready", 32'(req_ready), 32'(m));
    @(posedge clk); #1;
    tb_valid = '0;
    repeat (LAT - 1) begin
      @(negedge clk);
      chk("single_lat_low", 32'(rsp_valid), 32'(0));
    end
    @(negedge clk);
    chk("single_lat_high", 32'(rsp_valid), 32'(1));
    chk("single_sum", 32'(rsp_sum), 32'(exp_sum));
    chk("single_id", 32'(rsp_id), 32'(idx));
    @(posedge clk); #1;
    @(negedge clk);
    chk("single_cnt", 32'(ops_cnt), 32'(exp_cnt));
    @(posedge clk); #1;
  endtask

  initial begin
    tb_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      tb_a[i] = '0;
      tb_b[i] = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single requests, including sign-extension corner cases.
    do_single(0, 16'h0003, 16'h0004, 17'h00007, 16'd1);
    do_single(0, 16'h8000, 16'h8000, 17'h10000, 16'd2);
    do_single(0, 16'hFFFF, 16'h0001, 17'h00000, 16'd3);

    // Fairness with everyone requesting continuously.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      tb_a[i] = rnd_op();
      tb_b[i] = rnd_op();
    end
    tb_valid = '1;
    rsp_ready = 1'b1;
    gnt_log.delete();
    gnt_cyc.delete();
    run_cycles(5 * LAT, 1'b1, 1'b0);
    drain();
    chk("fair_n", 32'(gnt_log.size() >= 5), 32'(1));
    for (int k = 0; k < 5; k++) chk("fair_order", 32'(gnt_log[k]), 32'(k % NREQ));
    for (int k = 1; k < 5; k++) chk("fair_gap", 32'(gnt_cyc[k] - gnt_cyc[k-1]), 32'(LAT));
    chk("fair_cnt", 32'(ops_cnt), 32'(gnt_log.size()));

    // Backpressure: result held, no grants, release grants in the same cycle.
    tb_valid = '1;
    rsp_ready = 1'b0;
    run_cycles(LAT + 6, 1'b1, 1'b0);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_grant", 32'(|req_ready), 32'(1));
    @(posedge clk); #1;
    drain();

    // Pointer wrap and skip.
    do_reset();
    gnt_log.delete();
    rsp_ready = 1'b1;
    tb_a[3] = rnd_op();
    tb_b[3] = rnd_op();
    tb_valid = 4'b1000;
    run_cycles(1, 1'b1, 1'b0);
    tb_a[0] = rnd_op();
    tb_b[0] = rnd_op();
    tb_valid[0] = 1'b1;
    run_cycles(3 * LAT, 1'b1, 1'b0);
    drain();
    chk("wrap_g0", 32'(gnt_log[0]), 32'(3));
    chk("wrap_g1", 32'(gnt_log[1]), 32'(0));
    chk("wrap_g2", 32'(gnt_log[2]), 32'(3));

    // Reset while holding a result.
    tb_a[0] = rnd_op();
    tb_b[0] = rnd_op();
    tb_valid = 4'b0001;
    rsp_ready = 1'b0;
    run_cycles(LAT + 2, 1'b1, 1'b0);
    @(negedge clk);
    chk("hold_before_rst", 32'(rsp_valid), 32'(1));
    #2 rst = 1'b1;
    @(negedge clk);
    chk("hold_rst_cnt", 32'(ops_cnt), 32'(0));
    chk("hold_rst_valid", 32'(rsp_valid), 32'(0));
    chk("hold_rst_ready", 32'(req_ready), 32'(0));
    @(posedge clk); #1;
    tb_valid = '0;
    rst = 1'b0;
    @(posedge clk); #1;
    do_single(1, 16'h0003, 16'h0004, 17'h00007, 16'd1);

    // Randomized traffic with random backpressure and dropped requests.
    do_reset();
    gnt_log.delete();
    rsp_ready = 1'b1;
    run_cycles(4000, 1'b0, 1'b1);
    drain();
    chk("rand_cnt", 32'(ops_cnt), 32'(16'(gnt_log.size())));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
